// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: next-PC generator for the first fetch stage.
//   Selects the next fetch PC from commit/exception/EX/ID redirects, the
//   first taken BTB lane of the current bundle, or the sequential stride.
//   Keeps a circular return-address stack and sequences I-cache misses
//   through a RUN -> MISS -> REPLAY state machine.
//
// Optional feature macro: FETCH_BLOCK_ALIGN_EN
//   defined   : bundle truncated at the FETCH_WIDTH*INST_BYTES boundary;
//               lanes below the PC offset are never taken and the
//               sequential PC is aligned(PC)+stride.
//   undefined : every lane eligible; sequential PC is PC+stride.
//
// Ports
//   clk, reset (async, active low)
//   stall_i                          downstream stall, holds PC
//   recoverFlag_i/recoverPC_i        commit recovery redirect
//   exceptionFlag_i/exceptionPC_i    exception redirect
//   flagRecoverEX_i/targetAddrEX_i   EX redirect
//   flagRecoverID_i/targetAddrID_i   ID redirect, restores RAS pointer
//   flagCallID_i/callPCID_i          ID call push
//   flagRtrID_i                      ID return, target from restored TOS
//   recoverRasPtr_i                  RAS pointer checkpoint for ID redirect
//   btbHit_i/btbCtrlType_i/btbTarget_i/prediction_i   per-lane BTB info
//   icMiss_i/icFill_i                I-cache miss and refill-done pulse
//   pc_o, pcValid_o                  fetch PC and bundle valid
//   takenLane_o/takenValid_o         first taken lane of the bundle
//   rasTop_o, rasPtr_o               RAS top entry and pointer checkpoint
//   missReq_o, missAddr_o            refill request and block-aligned PC
module fetch_pc_gen #(
  parameter int unsigned FETCH_WIDTH = 4,
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned INST_BYTES  = 8,
  parameter int unsigned RAS_DEPTH   = 16,
  localparam int unsigned PTR_W      = $clog2(RAS_DEPTH),
  localparam int unsigned LANE_W     = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            stall_i,
  input  logic                            recoverFlag_i,
  input  logic [PC_WIDTH-1:0]             recoverPC_i,
  input  logic                            exceptionFlag_i,
  input  logic [PC_WIDTH-1:0]             exceptionPC_i,
  input  logic                            flagRecoverEX_i,
  input  logic [PC_WIDTH-1:0]             targetAddrEX_i,
  input  logic                            flagRecoverID_i,
  input  logic [PC_WIDTH-1:0]             targetAddrID_i,
  input  logic                            flagCallID_i,
  input  logic [PC_WIDTH-1:0]             callPCID_i,
  input  logic                            flagRtrID_i,
  input  logic [PTR_W-1:0]                recoverRasPtr_i,
  input  logic [FETCH_WIDTH-1:0]          btbHit_i,
  input  logic [2*FETCH_WIDTH-1:0]        btbCtrlType_i,
  input  logic [PC_WIDTH*FETCH_WIDTH-1:0] btbTarget_i,
  input  logic [FETCH_WIDTH-1:0]          prediction_i,
  input  logic                            icMiss_i,
  input  logic                            icFill_i,
  output logic [PC_WIDTH-1:0]             pc_o,
  output logic                            pcValid_o,
  output logic [LANE_W-1:0]               takenLane_o,
  output logic                            takenValid_o,
  output logic [PC_WIDTH-1:0]             rasTop_o,
  output logic [PTR_W-1:0]                rasPtr_o,
  output logic                            missReq_o,
  output logic [PC_WIDTH-1:0]             missAddr_o
);

  localparam int unsigned STRIDE = FETCH_WIDTH * INST_BYTES;
  localparam int unsigned CNT_W  = PTR_W + 1;

  localparam logic [1:0] CT_RET  = 2'b00;
  localparam logic [1:0] CT_CALL = 2'b01;
  localparam logic [1:0] CT_COND = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_MISS   = 2'd1,
    ST_REPLAY = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [PC_WIDTH-1:0]  ras_q [RAS_DEPTH];
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PC_WIDTH-1:0]  top_q, top_d;
  logic                 miss_req_q, miss_req_d;
  logic [PC_WIDTH-1:0]  miss_addr_q, miss_addr_d;

  logic                 ras_we;
  logic [PC_WIDTH-1:0]  ras_wdata;
  logic [PTR_W-1:0]     ptr_base;
  logic                 do_push, do_pop;
  logic [PC_WIDTH-1:0]  push_val;

  logic [FETCH_WIDTH-1:0] lane_taken;
  logic                   any_taken;
  logic [LANE_W-1:0]      first_lane;
  logic [1:0]             sel_type;
  logic [PC_WIDTH-1:0]    sel_target;

  logic [PC_WIDTH-1:0]  blk_pc;
  logic [PC_WIDTH-1:0]  lane_base;
  logic [PC_WIDTH-1:0]  seq_pc;
  logic                 hi_redirect;
  logic                 id_redirect;
  logic                 pc_valid_c;

  assign blk_pc = pc_q & ~PC_WIDTH'(STRIDE - 1);

`ifdef FETCH_BLOCK_ALIGN_EN
  logic [PC_WIDTH-1:0] pc_off;
  assign pc_off    = pc_q - blk_pc;
  assign lane_base = blk_pc;
  assign seq_pc    = blk_pc + PC_WIDTH'(STRIDE);
`else
  assign lane_base = pc_q;
  assign seq_pc    = pc_q + PC_WIDTH'(STRIDE);
`endif

  // Per-lane taken: hit and either predicted taken or unconditional.
  always_comb begin
    lane_taken = '0;
    for (int i = 0; i < int'(FETCH_WIDTH); i++) begin
      lane_taken[i] = btbHit_i[i] &
                      (prediction_i[i] | (btbCtrlType_i[2*i +: 2] != CT_COND));
`ifdef FETCH_BLOCK_ALIGN_EN
      if (PC_WIDTH'(i * INST_BYTES) < pc_off) lane_taken[i] = 1'b0;
`endif
    end
  end

  // Priority pick of the lowest taken lane.
  always_comb begin
    any_taken  = 1'b0;
    first_lane = '0;
    sel_type   = CT_RET;
    sel_target = '0;
    for (int i = int'(FETCH_WIDTH) - 1; i >= 0; i--) begin
      if (lane_taken[i]) begin
        any_taken  = 1'b1;
        first_lane = LANE_W'(i);
        sel_type   = btbCtrlType_i[2*i +: 2];
        sel_target = btbTarget_i[PC_WIDTH*i +: PC_WIDTH];
      end
    end
  end

  assign hi_redirect = recoverFlag_i | exceptionFlag_i | flagRecoverEX_i;
  assign id_redirect = flagRecoverID_i & ~stall_i & ~hi_redirect;
  // Reset term keeps the bundle-valid outputs low while reset is asserted.
  assign pc_valid_c  = reset & (state_q == ST_RUN) & ~icMiss_i & ~stall_i;

  // Next-state, next-PC and RAS operation selection.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    miss_req_d  = miss_req_q;
    miss_addr_d = miss_addr_q;
    ptr_base    = ptr_q;
    do_push     = 1'b0;
    do_pop      = 1'b0;
    push_val    = '0;

    if (hi_redirect) begin
      state_d    = ST_RUN;
      miss_req_d = 1'b0;
      if (recoverFlag_i)        pc_d = recoverPC_i;
      else if (exceptionFlag_i) pc_d = exceptionPC_i;
      else                      pc_d = targetAddrEX_i;
    end else if (id_redirect) begin
      state_d    = ST_RUN;
      miss_req_d = 1'b0;
      ptr_base   = recoverRasPtr_i;
      if (flagCallID_i) begin
        pc_d     = targetAddrID_i;
        do_push  = 1'b1;
        push_val = callPCID_i;
      end else if (flagRtrID_i) begin
        pc_d   = ras_q[recoverRasPtr_i];
        do_pop = 1'b1;
      end else begin
        pc_d = targetAddrID_i;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (icMiss_i) begin
            state_d     = ST_MISS;
            miss_req_d  = 1'b1;
            miss_addr_d = blk_pc;
          end else if (!stall_i) begin
            if (any_taken) begin
              case (sel_type)
                CT_RET: begin
                  pc_d   = top_q;
                  do_pop = 1'b1;
                end
                CT_CALL: begin
                  pc_d     = sel_target;
                  do_push  = 1'b1;
                  // Return address is the instruction after the call lane.
                  push_val = lane_base + (PC_WIDTH'(first_lane) + PC_WIDTH'(1)) *
                                         PC_WIDTH'(INST_BYTES);
                end
                default: pc_d = sel_target;
              endcase
            end else begin
              pc_d = seq_pc;
            end
          end
        end
        ST_MISS: begin
          if (icFill_i) begin
            state_d    = ST_REPLAY;
            miss_req_d = 1'b0;
          end
        end
        ST_REPLAY: begin
          state_d    = ST_RUN;
          miss_req_d = 1'b0;
        end
        default: begin
          state_d    = ST_RUN;
          miss_req_d = 1'b0;
        end
      endcase
    end
  end

  // RAS pointer/count/write update; push writes at the advanced pointer.
  always_comb begin
    ptr_d     = ptr_base;
    cnt_d     = cnt_q;
    ras_we    = 1'b0;
    ras_wdata = '0;
    if (do_push) begin
      ptr_d     = ptr_base + PTR_W'(1);
      ras_we    = 1'b1;
      ras_wdata = push_val;
      if (cnt_q != CNT_W'(RAS_DEPTH)) cnt_d = cnt_q + CNT_W'(1);
    end else if (do_pop) begin
      ptr_d = ptr_base - PTR_W'(1);
      if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
    end
    top_d = ras_we ? ras_wdata : ras_q[ptr_d];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      pc_q        <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      top_q       <= '0;
      miss_req_q  <= 1'b0;
      miss_addr_q <= '0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) ras_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      top_q       <= top_d;
      miss_req_q  <= miss_req_d;
      miss_addr_q <= miss_addr_d;
      if (ras_we) ras_q[ptr_d] <= ras_wdata;
    end
  end

  assign pc_o         = pc_q;
  assign pcValid_o    = pc_valid_c;
  assign takenValid_o = pc_valid_c & any_taken;
  assign takenLane_o  = (pc_valid_c & any_taken) ? first_lane : '0;
  assign rasTop_o     = top_q;
  assign rasPtr_o     = ptr_q;
  assign missReq_o    = miss_req_q;
  assign missAddr_o   = miss_addr_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: directed scenarios followed by a randomized run checked
// against a behavioural next-PC / return-stack model.
module tb_fetch_pc_gen;
  localparam int unsigned FW = 4;
  localparam int unsigned PW = 32;
  localparam int unsigned IB = 8;
  localparam int unsigned RD = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          stall, recoverFlag, exceptionFlag, flagRecoverEX;
  logic          flagRecoverID, flagCallID, flagRtrID;
  logic [31:0]   recoverPC, exceptionPC, targetAddrEX, targetAddrID, callPCID;
  logic [3:0]    recRasPtr;
  logic [3:0]    btbHit, pred;
  logic [7:0]    btbType;
  logic [127:0]  btbTgt;
  logic          icMiss, icFill;
  logic [31:0]   pc_o, rasTop_o, missAddr_o;
  logic          pcValid_o, takenValid_o, missReq_o;
  logic [1:0]    takenLane_o;
  logic [3:0]    rasPtr_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state
  logic [31:0] m_pc;
  logic [31:0] m_ras [RD];
  int          m_ptr;

  always #5 clk = ~clk;

  fetch_pc_gen #(.FETCH_WIDTH(FW), .PC_WIDTH(PW), .INST_BYTES(IB), .RAS_DEPTH(RD)) dut (
    .clk(clk), .reset(reset), .stall_i(stall),
    .recoverFlag_i(recoverFlag), .recoverPC_i(recoverPC),
    .exceptionFlag_i(exceptionFlag), .exceptionPC_i(exceptionPC),
    .flagRecoverEX_i(flagRecoverEX), .targetAddrEX_i(targetAddrEX),
    .flagRecoverID_i(flagRecoverID), .targetAddrID_i(targetAddrID),
    .flagCallID_i(flagCallID), .callPCID_i(callPCID), .flagRtrID_i(flagRtrID),
    .recoverRasPtr_i(recRasPtr), .btbHit_i(btbHit), .btbCtrlType_i(btbType),
    .btbTarget_i(btbTgt), .prediction_i(pred), .icMiss_i(icMiss), .icFill_i(icFill),
    .pc_o(pc_o), .pcValid_o(pcValid_o), .takenLane_o(takenLane_o),
    .takenValid_o(takenValid_o), .rasTop_o(rasTop_o), .rasPtr_o(rasPtr_o),
    .missReq_o(missReq_o), .missAddr_o(missAddr_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    stall = 0; recoverFlag = 0; exceptionFlag = 0; flagRecoverEX = 0;
    flagRecoverID = 0; flagCallID = 0; flagRtrID = 0;
    recoverPC = 0; exceptionPC = 0; targetAddrEX = 0; targetAddrID = 0; callPCID = 0;
    recRasPtr = 0; btbHit = 0; pred = 0; btbType = 0; btbTgt = 0;
    icMiss = 0; icFill = 0;
  endtask

  task automatic set_lane(input int ln, input logic [1:0] typ, input logic [31:0] tgt);
    btbHit[ln] = 1'b1;
    pred[ln] = 1'b1;
    btbType[2*ln +: 2] = typ;
    btbTgt[32*ln +: 32] = tgt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    m_pc = 0;
    m_ptr = 0;
    for (int i = 0; i < int'(RD); i++) m_ras[i] = 0;
  endtask

  function automatic int first_lane();
    int ln;
    ln = -1;
    for (int i = int'(FW) - 1; i >= 0; i--)
      if (btbHit[i] && (pred[i] || btbType[2*i +: 2] != 2'b11)) ln = i;
    return ln;
  endfunction

  // Spec-level next-PC and stack behaviour for one cycle (no I-cache misses).
  task automatic model_step();
    int ln;
    logic [31:0] old_pc;
    ln = first_lane();
    old_pc = m_pc;
    if (recoverFlag) m_pc = recoverPC;
    else if (exceptionFlag) m_pc = exceptionPC;
    else if (flagRecoverEX) m_pc = targetAddrEX;
    else if (!stall) begin
      if (flagRecoverID) begin
        if (flagCallID) begin
          m_ptr = (int'(recRasPtr) + 1) % RD;
          m_ras[m_ptr] = callPCID;
          m_pc = targetAddrID;
        end else if (flagRtrID) begin
          m_pc = m_ras[recRasPtr];
          m_ptr = (int'(recRasPtr) + RD - 1) % RD;
        end else begin
          m_ptr = int'(recRasPtr);
          m_pc = targetAddrID;
        end
      end else if (ln >= 0) begin
        case (btbType[2*ln +: 2])
          2'b00: begin
            m_pc = m_ras[m_ptr];
            m_ptr = (m_ptr + RD - 1) % RD;
          end
          2'b01: begin
            m_ptr = (m_ptr + 1) % RD;
            m_ras[m_ptr] = old_pc + 32'((ln + 1) * IB);
            m_pc = btbTgt[32*ln +: 32];
          end
          default: m_pc = btbTgt[32*ln +: 32];
        endcase
      end else begin
        m_pc = old_pc + 32'(FW * IB);
      end
    end
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] exp_pc;
    logic [31:0] tgt;
    logic [31:0] saved_top;
    int fl;

    clear_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_missreq", 32'(missReq_o), 32'h0);
    chk("rst_rasptr", 32'(rasPtr_o), 32'h0);
    chk("rst_rastop", rasTop_o, 32'h0);
    chk("rst_pcvalid", 32'(pcValid_o), 32'h0);
    reset = 1'b1;

    // 1: enter MISS with non-zero PC and pointer, then async reset
    flagRecoverID = 1; recRasPtr = 4'd5; flagCallID = 1; callPCID = 32'h77;
    targetAddrID = 32'h344;
    step(); clear_inputs();
    chk("id_call_pc", pc_o, 32'h344);
    chk("id_call_ptr", 32'(rasPtr_o), 32'd6);
    chk("id_call_top", rasTop_o, 32'h77);
    icMiss = 1;
    step(); icMiss = 0;
    chk("miss1_req", 32'(missReq_o), 32'h1);
    chk("miss1_addr", missAddr_o, 32'h340);
    chk("miss1_pc", pc_o, 32'h344);
    step();
    chk("miss1_hold", 32'(missReq_o), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("arst_pc", pc_o, 32'h0);
    chk("arst_missreq", 32'(missReq_o), 32'h0);
    chk("arst_rasptr", 32'(rasPtr_o), 32'h0);
    chk("arst_pcvalid", 32'(pcValid_o), 32'h0);
    step();
    reset = 1'b1;
    #1;
    chk("arst_run_valid", 32'(pcValid_o), 32'h1);
    step();
    chk("seq_stride", pc_o, 32'h20);

    // 2: lane2 call then lane0 return
    recoverFlag = 1; recoverPC = 32'h100;
    step(); clear_inputs();
    chk("redir_pc", pc_o, 32'h100);
    set_lane(2, 2'b01, 32'h400);
    btbHit[1] = 1'b1; btbType[3:2] = 2'b11; pred[1] = 1'b0;
    #1;
    chk("call_tvalid", 32'(takenValid_o), 32'h1);
    chk("call_tlane", 32'(takenLane_o), 32'h2);
    step(); clear_inputs();
    chk("call_pc", pc_o, 32'h400);
    chk("call_top", rasTop_o, 32'h118);
    chk("call_ptr", 32'(rasPtr_o), 32'h1);
    set_lane(0, 2'b00, 32'hdead0000);
    step(); clear_inputs();
    chk("ret_pc", pc_o, 32'h118);
    chk("ret_ptr", 32'(rasPtr_o), 32'h0);

    // 3: 17 pushes overflow a 16-entry stack, then 16 LIFO pops
    do_reset();
    exp_pc = 0;
    for (int k = 0; k < 17; k++) begin
      tgt = 32'h1000 + 32'(k) * 32'h100;
      set_lane(0, 2'b01, tgt);
      q.push_back(exp_pc + 32'd8);
      step(); clear_inputs();
      exp_pc = tgt;
      chk("push_pc", pc_o, exp_pc);
    end
    chk("ovf_ptr", 32'(rasPtr_o), 32'h1);
    chk("ovf_top", rasTop_o, q[16]);
    saved_top = q[16];
    for (int k = 0; k < 16; k++) begin
      set_lane(0, 2'b00, 32'h0);
      step(); clear_inputs();
      chk("pop_lifo", pc_o, q.pop_back());
    end
    chk("pop_ptr", 32'(rasPtr_o), 32'h1);

    // 4: miss at 0x200, refill, single replay cycle
    recoverFlag = 1; recoverPC = 32'h200;
    step(); clear_inputs();
    icMiss = 1;
    #1;
    chk("miss_pcvalid", 32'(pcValid_o), 32'h0);
    step(); icMiss = 0;
    chk("miss_req", 32'(missReq_o), 32'h1);
    chk("miss_addr", missAddr_o, 32'h200);
    chk("miss_pc", pc_o, 32'h200);
    step();
    chk("miss_hold_req", 32'(missReq_o), 32'h1);
    chk("miss_hold_valid", 32'(pcValid_o), 32'h0);
    icFill = 1;
    step(); icFill = 0;
    chk("replay_req", 32'(missReq_o), 32'h0);
    chk("replay_valid", 32'(pcValid_o), 32'h0);
    step();
    chk("rerun_pc", pc_o, 32'h200);
    chk("rerun_valid", 32'(pcValid_o), 32'h1);

    // 5: EX redirect under stall beats ID redirect; stack untouched
    stall = 1; flagRecoverEX = 1; targetAddrEX = 32'h800;
    flagRecoverID = 1; recRasPtr = 4'd7; flagCallID = 1; callPCID = 32'h99;
    set_lane(0, 2'b01, 32'h1234);
    step(); clear_inputs();
    chk("ex_pc", pc_o, 32'h800);
    chk("ex_ptr", 32'(rasPtr_o), 32'h1);
    chk("ex_top", rasTop_o, saved_top);

    // 6: ID redirect with pointer restore and call push; lane3 call ignored
    flagRecoverID = 1; recRasPtr = 4'd3; flagCallID = 1; flagRtrID = 1;
    callPCID = 32'h50; targetAddrID = 32'h900;
    set_lane(3, 2'b01, 32'ha00);
    step(); clear_inputs();
    chk("idr_pc", pc_o, 32'h900);
    chk("idr_ptr", 32'(rasPtr_o), 32'h4);
    chk("idr_top", rasTop_o, 32'h50);
    set_lane(0, 2'b00, 32'h0);
    step(); clear_inputs();
    chk("idr_ret_pc", pc_o, 32'h50);
    chk("idr_ret_ptr", 32'(rasPtr_o), 32'h3);

    // Randomized run against the reference model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      stall         = ($urandom % 4) == 0;
      recoverFlag   = ($urandom % 32) == 0;
      exceptionFlag = ($urandom % 32) == 0;
      flagRecoverEX = ($urandom % 16) == 0;
      flagRecoverID = ($urandom % 6) == 0;
      flagCallID    = $urandom % 2;
      flagRtrID     = $urandom % 2;
      recRasPtr     = 4'($urandom);
      recoverPC     = $urandom & ~32'h7;
      exceptionPC   = $urandom & ~32'h7;
      targetAddrEX  = $urandom & ~32'h7;
      targetAddrID  = $urandom & ~32'h7;
      callPCID      = $urandom & ~32'h7;
      btbHit        = 4'($urandom) & 4'($urandom);
      pred          = 4'($urandom);
      btbType       = 8'($urandom);
      for (int i = 0; i < int'(FW); i++) btbTgt[32*i +: 32] = $urandom & ~32'h7;
      #1;
      fl = first_lane();
      chk("rnd_pcvalid", 32'(pcValid_o), 32'(!stall));
      chk("rnd_tvalid", 32'(takenValid_o), 32'(!stall && fl >= 0));
      chk("rnd_tlane", 32'(takenLane_o), (!stall && fl >= 0) ? 32'(fl) : 32'h0);
      model_step();
      step();
      chk("rnd_pc", pc_o, m_pc);
      chk("rnd_ptr", 32'(rasPtr_o), 32'(m_ptr));
      chk("rnd_top", rasTop_o, m_ras[m_ptr]);
    end
    clear_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
